// File: rtl/spi_slv16.sv
// spi_slv16 : 16-bit SPI responder (mode 3, MSB first).
//
// SCLK idles high. Data changes on the SCLK fall and is sampled on the SCLK
// rise. The module receives one 16-bit word on MOSI and returns a preloaded
// response word on MISO. It is used as the bench model of the inertial/A2D
// slave and as the RTL slave for bring-up.
//
// Parameters
//   SYNC_STAGES  metastability flops on SS_n/SCLK/MOSI (legal 2..3)
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset
//   SS_n         slave select, active low, asynchronous to clk
//   SCLK         serial clock, idles high, asynchronous to clk
//   MOSI         serial data from master
//   MISO         serial data to master (shift register MSB)
//   wrt          1-clk strobe: latch tx_data into the transmit buffer
//   tx_data      response word for the next frame
//   rx_data      last complete word received
//   rdy          1-clk pulse when rx_data updates
//   err          1-clk pulse when a frame ends with other than 16 SCLK rises
//   o_dbg_state  current FSM state (IDLE=0, FRONT=1, SHIFT=2)
//
// Build option
//   MISO_TRISTATE_EN  when defined, MISO is high-Z while deselected (shared
//                     bus). Otherwise MISO is always driven and holds its last
//                     value between frames.
//
// Requires f_clk >= 8x f_SCLK.
module spi_slv16 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wrt,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rdy,
  output logic        err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FRONT = 2'd1, SHIFT = 2'd2} state_t;

  // Synchronizers plus one extra sample of SS_n/SCLK for edge detection.
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_ss_prev;
  logic                   r_sclk_prev;
  // r_warm fills with ones once the chain carries real pin samples. r_armed
  // is set only after SS_n has been seen high from the pin. This prevents a
  // reset taken with SS_n held low from producing a false fall edge.
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_armed;

  logic w_ss, w_sclk, w_mosi;
  logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;

  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_fall   = r_armed & r_ss_prev & ~w_ss;
  assign w_ss_rise   = ~r_ss_prev & w_ss;
  assign w_sclk_rise = ~r_sclk_prev & w_sclk;
  assign w_sclk_fall = r_sclk_prev & ~w_sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '1;
      r_mosi_sync <= '0;
      r_ss_prev   <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_warm      <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_ss_prev   <= w_ss;
      r_sclk_prev <= w_sclk;
      r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      if (r_warm[SYNC_STAGES-1] && w_ss) r_armed <= 1'b1;
    end
  end

  // FSM state and datapath registers.
  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_tx_buf;
  logic [15:0] r_shft;
  logic [4:0]  r_bit_cnt;
  logic        r_mosi_smpl;

  logic w_load, w_sample, w_shift, w_done, w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_load   = 1'b0;
    w_sample = 1'b0;
    w_shift  = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_load = 1'b1;
          w_nxt  = FRONT;
        end
      end
      FRONT: begin
        // The fall before the first rise is the front porch. It is not a shift.
        if (w_ss_rise) begin
          w_err = 1'b1;
          w_nxt = IDLE;
        end else if (w_sclk_rise) begin
          w_sample = 1'b1;
          w_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          // No SCLK fall follows the 16th rise, so the last bit goes in here.
          w_shift = 1'b1;
          if (r_bit_cnt == 5'd16) w_done = 1'b1;
          else                    w_err  = 1'b1;
          w_nxt = IDLE;
        end else begin
          w_sample = w_sclk_rise;
          w_shift  = w_sclk_fall;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_buf    <= '0;
      r_shft      <= '0;
      r_bit_cnt   <= '0;
      r_mosi_smpl <= 1'b0;
      rx_data     <= '0;
      rdy         <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (wrt) r_tx_buf <= tx_data;
      // A wrt in the same clock as the frame start takes effect immediately.
      if (w_load) begin
        r_shft    <= wrt ? tx_data : r_tx_buf;
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shft <= {r_shft[14:0], r_mosi_smpl};
      end
      if (w_sample) begin
        r_mosi_smpl <= w_mosi;
        // Saturate at 17 so overlong frames still end with err.
        if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_done) rx_data <= {r_shft[14:0], r_mosi_smpl};
      rdy <= w_done;
      err <= w_err;
    end
  end

`ifdef MISO_TRISTATE_EN
  assign MISO = w_ss ? 1'bz : r_shft[15];
`else
  assign MISO = r_shft[15];
`endif

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_slv16.sv
// Directed testbench for spi_slv16. A mode-3 master runs at 32 clk per SCLK.
module tb_spi_slv16;

  logic        clk;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        wrt;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rdy;
  logic        err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int rdy_seen = 0;
  int err_seen = 0;
  int rdy_base;
  int err_base;
  logic [15:0] rd;
  logic [15:0] rd2;

  spi_slv16 #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .SS_n        (SS_n),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .wrt         (wrt),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rdy         (rdy),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters. A pulse wider than 1 clk counts more than once.
  always @(negedge clk) begin
    if (rdy === 1'b1) rdy_seen++;
    if (err === 1'b1) err_seen++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle_miso(input string tag, input logic exp_held);
`ifdef MISO_TRISTATE_EN
    check(tag, {15'd0, (MISO === 1'bz)}, 16'd1);
`else
    check(tag, {15'd0, (MISO === 1'bz)}, 16'd0);
    check({tag, "_held"}, {15'd0, MISO}, {15'd0, exp_held});
`endif
  endtask

  // driver tasks
  task automatic load_tx(input logic [15:0] d);
    @(negedge clk);
    wrt = 1'b1;
    tx_data = d;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  // Drop SS_n and run a 16-clk front porch. With do_wrt, wrt is pulsed in
  // the clock where the synchronized fall is detected.
  task automatic ss_low(input logic do_wrt, input logic [15:0] d);
    @(negedge clk);
    SS_n = 1'b0;
    if (do_wrt) begin
      @(negedge clk);
      @(negedge clk);
      wrt = 1'b1;
      tx_data = d;
      @(negedge clk);
      wrt = 1'b0;
      repeat (13) @(negedge clk);
    end else begin
      repeat (16) @(negedge clk);
    end
  endtask

  // Clock n bits MSB first (zeros past bit 16). MISO is captured on each
  // SCLK rise. An optional wrt pulse is sent after bit mid_bit.
  task automatic shift_bits(input logic [15:0] cmd, input int n, input int mid_bit,
                            input logic [15:0] mid_d, output logic [15:0] rd_o);
    logic [15:0] c;
    c = cmd;
    rd_o = '0;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? c[15-i] : 1'b0;
      repeat (16) @(negedge clk);
      SCLK = 1'b1;
      rd_o = {rd_o[14:0], MISO};
      if (i == mid_bit) begin
        @(negedge clk);
        wrt = 1'b1;
        tx_data = mid_d;
        @(negedge clk);
        wrt = 1'b0;
        repeat (14) @(negedge clk);
      end else begin
        repeat (16) @(negedge clk);
      end
    end
  endtask

  task automatic ss_high(input int gap);
    repeat (16) @(negedge clk);
    SS_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    wrt = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // reset state
    check("rst_rx", rx_data, 16'h0000);
    check("rst_rdy", {15'd0, rdy}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_state", {14'd0, dbg_state}, 16'd0);
    check_idle_miso("rst_miso", 1'b0);

    // 1: single frame
    rdy_base = rdy_seen; err_base = err_seen;
    load_tx(16'h3C5A);
    ss_low(1'b0, 16'h0);
    shift_bits(16'hA5C3, 16, -1, 16'h0, rd);
    ss_high(20);
    check("t1_rx", rx_data, 16'hA5C3);
    check("t1_master_rd", rd, 16'h3C5A);
    check("t1_rdy_cnt", 16'(rdy_seen - rdy_base), 16'd1);
    check("t1_err_cnt", 16'(err_seen - err_base), 16'd0);
    check_idle_miso("t1_miso", 1'b1);  // shift register now holds 0xA5C3

    // 2: back-to-back frames with SS_n high for a single clk between them
    rdy_base = rdy_seen; err_base = err_seen;
    load_tx(16'h0001);
    ss_low(1'b0, 16'h0);
    shift_bits(16'h1234, 16, 3, 16'h8000, rd);
    ss_high(0);
    ss_low(1'b0, 16'h0);
    check("t2_rx_first", rx_data, 16'h1234);
    shift_bits(16'hFFFF, 16, -1, 16'h0, rd2);
    ss_high(20);
    check("t2_master_rd1", rd, 16'h0001);
    check("t2_master_rd2", rd2, 16'h8000);
    check("t2_rx_second", rx_data, 16'hFFFF);
    check("t2_rdy_cnt", 16'(rdy_seen - rdy_base), 16'd2);
    check("t2_err_cnt", 16'(err_seen - err_base), 16'd0);

    // 3: short frame of 8 SCLKs
    rdy_base = rdy_seen; err_base = err_seen;
    ss_low(1'b0, 16'h0);
    shift_bits(16'h5A00, 8, -1, 16'h0, rd);
    ss_high(20);
    check("t3_err_cnt", 16'(err_seen - err_base), 16'd1);
    check("t3_rdy_cnt", 16'(rdy_seen - rdy_base), 16'd0);
    check("t3_rx_kept", rx_data, 16'hFFFF);

    // 4: wrt at frame start wins over tx_buf; mid-frame wrt is harmless
    rdy_base = rdy_seen; err_base = err_seen;
    load_tx(16'h1111);
    ss_low(1'b1, 16'hBEEF);
    shift_bits(16'h0F0F, 16, 7, 16'h0000, rd);
    ss_high(20);
    check("t4_master_rd", rd, 16'hBEEF);
    check("t4_rx", rx_data, 16'h0F0F);
    check("t4_rdy_cnt", 16'(rdy_seen - rdy_base), 16'd1);

    // overlong frame of 17 SCLKs: the bit counter saturates and the frame errors
    rdy_base = rdy_seen; err_base = err_seen;
    ss_low(1'b0, 16'h0);
    shift_bits(16'hC3C3, 17, -1, 16'h0, rd);
    ss_high(20);
    check("sat_err_cnt", 16'(err_seen - err_base), 16'd1);
    check("sat_rdy_cnt", 16'(rdy_seen - rdy_base), 16'd0);
    check("sat_rx_kept", rx_data, 16'h0F0F);

    // 5: reset after 5 bits with SS_n held low
    ss_low(1'b0, 16'h0);
    shift_bits(16'h5555, 5, -1, 16'h0, rd);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rx_rst", rx_data, 16'h0000);
    check("t5_miso_rst", {15'd0, MISO}, 16'd0);
    check("t5_state_rst", {14'd0, dbg_state}, 16'd0);
    rdy_base = rdy_seen; err_base = err_seen;
    shift_bits(16'hAAA0, 11, -1, 16'h0, rd);
    check("t5_state_ignored", {14'd0, dbg_state}, 16'd0);
    ss_high(20);
    check("t5_err_none", 16'(err_seen - err_base), 16'd0);
    check("t5_rdy_none", 16'(rdy_seen - rdy_base), 16'd0);
    check("t5_rx_still0", rx_data, 16'h0000);
    rdy_base = rdy_seen;
    ss_low(1'b0, 16'h0);
    shift_bits(16'hAAAA, 16, -1, 16'h0, rd);
    ss_high(20);
    check("t5_rx_next", rx_data, 16'hAAAA);
    check("t5_master_rd", rd, 16'h0000);
    check("t5_rdy_cnt", 16'(rdy_seen - rdy_base), 16'd1);
    check_idle_miso("t6_miso_end", 1'b1);  // shift register now holds 0xAAAA

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
